lamp_phase_scheduler: RTL and testbench
=======================================

Name: lamp_phase_scheduler

Overview:
- Intersection controller that sequences two cyclic lamps, north-south (NS) and east-west (EW), plus one pedestrian walk signal.
- Built around a tick prescaler and a phase timer.
- Replaces the free-running single-lamp cycle with timed phases, a mandatory all-red clearance, pedestrian-request service and a flashing-yellow fallback.
- Outputs drive the lamp vectors directly.

Parameters:
- TICK_DIV, 50000000: clock cycles per tick (≥2).
- GREEN_TICKS, 20: green phase length in ticks (≥1).
- YELLOW_TICKS, 3: yellow phase length in ticks (≥1).
- ALLRED_TICKS, 1: all-red clearance length in ticks (≥1).
- PED_TICKS, 8: walk phase length in ticks (≥1).
- MIN_GREEN, 5: minimum green ticks before a pedestrian request may cut green short (1..GREEN_TICKS).

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = normal sequencing; 0 = flashing-yellow mode.
- ped_req  in  1  pedestrian request, level or pulse, sampled every cycle.
- light_ns  out  [0:2]  NS lamp: RED=3'b100, GREEN=3'b010, YELLOW=3'b001, OFF=3'b000. light_ns[0] is the red bit.
- light_ew  out  [0:2]  EW lamp, same encoding as light_ns.
- walk  out  1  pedestrian walk lamp.
- ped_ack  out  1  one-cycle pulse on entry to PED_WALK.
- phase  out  3  current state code.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - phase=ALLRED(0); light_ns=light_ew=RED; walk=0; ped_ack=0.
  - ped_pending=0; next_dir=NS; prescaler=0; timer=ALLRED_TICKS.
- Reset mid-phase: abandons the phase immediately, with no yellow.
- Prescaler:
  - Counts 0..TICK_DIV-1. Internal tick=1 on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - Reloads to 0 on every state transition, so every phase lasts exactly N*TICK_DIV cycles.
- Timer:
  - Loaded with the phase length on state entry.
  - On each tick: if timer==1, transition; otherwise decrement.
  - Outputs for the new state appear on the edge that takes the transition.
- States (code: lights, exit):
  - ALLRED(0): NS=RED, EW=RED. On expiry, go to PED_WALK if ped_pending, else to the green of next_dir.
  - NS_GREEN(1): NS=GREEN, EW=RED. Go to NS_YELLOW on expiry or on early pedestrian cut.
  - NS_YELLOW(2): NS=YELLOW, EW=RED. On expiry, go to ALLRED and set next_dir=EW.
  - EW_GREEN(3): NS=RED, EW=GREEN. Go to EW_YELLOW on expiry or early cut.
  - EW_YELLOW(4): NS=RED, EW=YELLOW. On expiry, go to ALLRED and set next_dir=NS.
  - PED_WALK(5): both RED, walk=1. On expiry, clear ped_pending and go to the green of next_dir; no second all-red.
  - FLASH(6): both lamps YELLOW/OFF, toggling every tick. Starts YELLOW on entry. walk=0.
- Early cut: in a green state, at a tick where completed green ticks (including this tick) ≥ MIN_GREEN and ped_pending=1, exit to yellow on that tick.
- ped_pending:
  - Set by ped_req=1 in any state except PED_WALK and FLASH; requests in those states are ignored.
  - A set and a clear in the same cycle (the PED_WALK exit edge) resolves to clear.
- enable:
  - enable=0 in any state: next edge enters FLASH, clears ped_pending, reloads the prescaler.
  - enable rising while in FLASH: next edge enters ALLRED with next_dir=NS and timer=ALLRED_TICKS.
  - reset has priority over enable.
- ped_ack=1 only on the first cycle of PED_WALK.
- Invariants:
  - light_ns and light_ew are never both non-RED outside FLASH.
  - walk=1 only in PED_WALK.

Test Plan (TICK_DIV=4, GREEN=5, YELLOW=2, ALLRED=1, PED=3, MIN_GREEN=2):
1. Reset, then free-run with enable=1, ped_req=0:
   - Phase sequence 0,1,2,0,3,4,0,1.
   - Dwell per phase, in cycles: 4, 20, 8, 4, 20, 8, 4.
   - NS goes GREEN on cycle 4 after reset release.
2. ped_req pulsed one cycle at cycle 10 (NS_GREEN, 1 tick done):
   - Green ends at the cycle-12 tick (2 ticks). NS_YELLOW runs 8 cycles, then ALLRED 4 cycles.
   - Then PED_WALK: walk=1 for 12 cycles, ped_ack high on its first cycle only.
   - Then EW_GREEN.
3. ped_req held high through PED_WALK:
   - No re-entry into walk after it ends. pending is re-set only once the green state begins.
   - The next ALLRED then serves walk again.
4. enable=0 mid-NS_GREEN:
   - FLASH on the next edge; lamps 001/000 alternating every 4 cycles; walk=0.
   - Re-enable: ALLRED for 4 cycles, then NS_GREEN.
5. reset asserted mid-EW_YELLOW for 1 cycle:
   - Next edge: both RED, phase=0, walk=0. A pending request is discarded.
6. ped_req asserted during ALLRED after a yellow:
   - PED_WALK follows that ALLRED directly, with no extra green in between.

Source files
------------

// File: rtl/lamp_phase_scheduler.sv
// lamp_phase_scheduler
// Two-direction intersection controller with a walk phase. A prescaler turns
// the clock into ticks; a per-phase down-counter times each phase in ticks.
// Sequence: ALLRED -> green -> yellow -> ALLRED -> other green ..., with a
// pedestrian walk served from ALLRED, early green cut for waiting pedestrians,
// and a flashing-yellow mode while enable is low. Every output is a flop.
module lamp_phase_scheduler #(
  parameter int TICK_DIV     = 50000000,  // clock cycles per tick (>= 2)
  parameter int GREEN_TICKS  = 20,        // green length in ticks
  parameter int YELLOW_TICKS = 3,         // yellow length in ticks
  parameter int ALLRED_TICKS = 1,         // all-red clearance in ticks
  parameter int PED_TICKS    = 8,         // walk length in ticks
  parameter int MIN_GREEN    = 5          // green ticks before a walk may cut it
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ped_req,
  output logic [0:2] light_ns,
  output logic [0:2] light_ew,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  // Widest phase length decides the timer width.
  localparam int MAX_GY    = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int MAX_AP    = (ALLRED_TICKS > PED_TICKS) ? ALLRED_TICKS : PED_TICKS;
  localparam int MAX_TICKS = (MAX_GY > MAX_AP) ? MAX_GY : MAX_AP;
  localparam int TW        = $clog2(MAX_TICKS + 1);
  localparam int PW        = $clog2(TICK_DIV);

  // With the timer counting down from GREEN_TICKS, the tick that completes
  // MIN_GREEN green ticks is the one seen while timer <= CUT_AT.
  localparam int CUT_AT    = GREEN_TICKS - MIN_GREEN + 1;

  typedef enum logic [2:0] {
    ALLRED    = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    PED_WALK  = 3'd5,
    FLASH     = 3'd6
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  // Lamp encodings; index 0 of the vector is the red bit.
  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_GREEN  = 3'b010;
  localparam logic [0:2] LAMP_YELLOW = 3'b001;
  localparam logic [0:2] LAMP_OFF    = 3'b000;

  state_t          state_q, state_d;
  dir_t            dir_q, dir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            flash_q, flash_d;
  logic            tick;
  logic            is_green;
  logic            early_cut;
  logic [0:2]      ns_d, ew_d;
  logic            walk_d, ack_d;

  // Phase length in ticks, loaded into the timer on entry to a state.
  function automatic logic [TW-1:0] phase_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_len = TW'(GREEN_TICKS);
      NS_YELLOW, EW_YELLOW: phase_len = TW'(YELLOW_TICKS);
      PED_WALK:             phase_len = TW'(PED_TICKS);
      default:              phase_len = TW'(ALLRED_TICKS);
    endcase
  endfunction

  assign tick      = (cnt_q == PW'(TICK_DIV - 1));
  assign is_green  = (state_q == NS_GREEN) || (state_q == EW_GREEN);
  assign early_cut = is_green && pend_q && (timer_q <= TW'(CUT_AT));
  assign phase     = state_q;

  // Next-state, timer, prescaler and pedestrian-pending logic.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    dir_d   = dir_q;
    timer_d = timer_q;
    cnt_d   = tick ? '0 : cnt_q + PW'(1);
    pend_d  = pend_q;
    flash_d = flash_q;

    // A request is remembered everywhere except while walking or flashing.
    if (ped_req && (state_q != PED_WALK) && (state_q != FLASH)) begin
      pend_d = 1'b1;
    end

    if (!enable) begin
      // Flashing-yellow fallback; pending requests are dropped.
      pend_d = 1'b0;
      if (state_q != FLASH) begin
        state_d = FLASH;
        flash_d = 1'b1;
        cnt_d   = '0;
      end else if (tick) begin
        flash_d = ~flash_q;
      end
    end else if (state_q == FLASH) begin
      // Leaving flash always restarts from a clearance, serving NS first.
      state_d = ALLRED;
      dir_d   = DIR_NS;
      timer_d = TW'(ALLRED_TICKS);
      cnt_d   = '0;
    end else if (tick) begin
      if ((timer_q == TW'(1)) || early_cut) begin
        cnt_d = '0;
        case (state_q)
          ALLRED: begin
            if (pend_q) begin
              state_d = PED_WALK;
            end else if (dir_q == DIR_NS) begin
              state_d = NS_GREEN;
            end else begin
              state_d = EW_GREEN;
            end
          end
          NS_GREEN:  state_d = NS_YELLOW;
          NS_YELLOW: begin
            state_d = ALLRED;
            dir_d   = DIR_EW;
          end
          EW_GREEN:  state_d = EW_YELLOW;
          EW_YELLOW: begin
            state_d = ALLRED;
            dir_d   = DIR_NS;
          end
          PED_WALK: begin
            // Walk already provides clearance, so go straight to green.
            // The clear overrides a request seen on this same edge.
            pend_d  = 1'b0;
            state_d = (dir_q == DIR_NS) ? NS_GREEN : EW_GREEN;
          end
          default:   state_d = ALLRED;
        endcase
        timer_d = phase_len(state_d);
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
  end

  // Output decode from the state being entered, so lamps change on the
  // same edge as the state.
  always_comb begin
    ns_d   = LAMP_RED;
    ew_d   = LAMP_RED;
    walk_d = 1'b0;
    ack_d  = (state_d == PED_WALK) && (state_q != PED_WALK);
    case (state_d)
      NS_GREEN:  ns_d = LAMP_GREEN;
      NS_YELLOW: ns_d = LAMP_YELLOW;
      EW_GREEN:  ew_d = LAMP_GREEN;
      EW_YELLOW: ew_d = LAMP_YELLOW;
      PED_WALK:  walk_d = 1'b1;
      FLASH: begin
        ns_d = flash_d ? LAMP_YELLOW : LAMP_OFF;
        ew_d = flash_d ? LAMP_YELLOW : LAMP_OFF;
      end
      default: begin
        ns_d = LAMP_RED;
        ew_d = LAMP_RED;
      end
    endcase
  end

  // State, timing and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    if (reset) begin
      state_q  <= ALLRED;
      dir_q    <= DIR_NS;
      timer_q  <= TW'(ALLRED_TICKS);
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      flash_q  <= 1'b0;
      light_ns <= LAMP_RED;
      light_ew <= LAMP_RED;
      walk     <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
      light_ns <= ns_d;
      light_ew <= ew_d;
      walk     <= walk_d;
      ped_ack  <= ack_d;
    end
  end

endmodule

// File: tb/tb_lamp_phase_scheduler.sv
// Self-checking bench for lamp_phase_scheduler: directed scenarios plus a
// randomized run, all compared cycle by cycle against a reference model that
// tracks elapsed cycles per phase.
module tb_lamp_phase_scheduler;

  localparam int TD  = 4;
  localparam int GRN = 5;
  localparam int YEL = 2;
  localparam int ARD = 1;
  localparam int PED = 3;
  localparam int MING = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       ped_req = 1'b0;
  logic [0:2] light_ns, light_ew;
  logic       walk, ped_ack;
  logic [2:0] phase;

  lamp_phase_scheduler #(
    .TICK_DIV(TD), .GREEN_TICKS(GRN), .YELLOW_TICKS(YEL),
    .ALLRED_TICKS(ARD), .PED_TICKS(PED), .MIN_GREEN(MING)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ped_req(ped_req),
    .light_ns(light_ns), .light_ew(light_ew), .walk(walk),
    .ped_ack(ped_ack), .phase(phase)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase codes: 0 allred, 1 ns green, 2 ns yellow, 3 ew green,
  // 4 ew yellow, 5 walk, 6 flash. m_e = cycles already spent in the phase.
  int m_phase = 0, m_e = 0, m_dir = 0;
  bit m_pend = 0, m_fy = 0, m_ack = 0;

  function automatic int len_of(int p);
    case (p)
      1, 3:    return GRN;
      2, 4:    return YEL;
      5:       return PED;
      default: return ARD;
    endcase
  endfunction

  function automatic void model_step(bit rst, bit en, bit req);
    int  done, nxt;
    bit  tk, setr, newp;
    m_ack = 0;
    if (rst) begin
      m_phase = 0; m_e = 0; m_pend = 0; m_dir = 0; m_fy = 0;
      return;
    end
    done = (m_e + 1) / TD;
    tk   = ((m_e + 1) % TD) == 0;
    setr = req && m_phase != 5 && m_phase != 6;
    if (!en) begin
      if (m_phase != 6) begin
        m_phase = 6; m_e = 0; m_fy = 1;
      end else begin
        if (tk) m_fy = !m_fy;
        m_e++;
      end
      m_pend = 0;
      return;
    end
    if (m_phase == 6) begin
      m_phase = 0; m_dir = 0; m_e = 0;
      return;
    end
    newp = m_pend | setr;
    if ((tk && done == len_of(m_phase)) ||
        ((m_phase == 1 || m_phase == 3) && tk && m_pend && done >= MING)) begin
      case (m_phase)
        0: nxt = m_pend ? 5 : (m_dir == 0 ? 1 : 3);
        1: nxt = 2;
        2: begin nxt = 0; m_dir = 1; end
        3: nxt = 4;
        4: begin nxt = 0; m_dir = 0; end
        default: begin nxt = (m_dir == 0) ? 1 : 3; newp = 0; end
      endcase
      m_ack   = (nxt == 5);
      m_phase = nxt;
      m_e     = 0;
    end else begin
      m_e++;
    end
    m_pend = newp;
  endfunction

  function automatic logic [2:0] exp_ns(int p, bit fy);
    case (p)
      1:       return 3'b010;
      2:       return 3'b001;
      6:       return fy ? 3'b001 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(int p, bit fy);
    case (p)
      3:       return 3'b010;
      4:       return 3'b001;
      6:       return fy ? 3'b001 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  // ---------------- cycle bookkeeping ----------------
  typedef struct { int ph; int dw; } run_t;
  run_t trace[$];
  int cyc = 0, since = 0, last_ph = 0, run_len = 0, first_green = -1;
  int walk_cnt = 0, ack_cnt = 0, low_left = 0;

  task automatic step();
    logic [10:0] exp_v;
    @(posedge clock);
    model_step(reset, enable, ped_req);
    #1;
    exp_v = {3'(m_phase), exp_ns(m_phase, m_fy), exp_ew(m_phase, m_fy), m_phase == 5, m_ack};
    check($sformatf("cyc%0d{ph,ns,ew,walk,ack}", cyc),
          32'({phase, light_ns, light_ew, walk, ped_ack}), 32'(exp_v));
    if (phase != 3'd6)
      check("inv_lamps_not_both_go", 32'(light_ns != 3'b100 && light_ew != 3'b100), 0);
    if (walk) check("inv_walk_phase", 32'(phase), 5);
    if (reset) begin
      since = 0; trace.delete(); last_ph = int'(phase); run_len = 1;
      first_green = -1; walk_cnt = 0; ack_cnt = 0;
    end else begin
      since++;
      if (int'(phase) == last_ph) run_len++;
      else begin
        trace.push_back('{last_ph, run_len});
        last_ph = int'(phase); run_len = 1;
      end
      if (phase == 3'd1 && first_green < 0) first_green = since;
      walk_cnt += int'(walk);
      ack_cnt  += int'(ped_ack);
    end
    cyc++;
  endtask

  task automatic do_reset();
    enable = 1; ped_req = 0; reset = 1;
    step();
    reset = 0;
  endtask

  task automatic run_to(input int n);
    for (int g = 0; g < 2000 && since < n; g++) step();
    if (since < n) check("run_to_bound", since, n);
  endtask

  int exp_ph[7] = '{0, 1, 2, 0, 3, 4, 0};
  int exp_dw[7] = '{4, 20, 8, 4, 20, 8, 4};

  initial begin
    // 1. Free run from reset.
    do_reset();
    check("t1_reset_phase", 32'(phase), 0);
    check("t1_reset_ns", 32'(light_ns), 3'b100);
    check("t1_reset_ew", 32'(light_ew), 3'b100);
    check("t1_reset_walk_ack", 32'({walk, ped_ack}), 0);
    run_to(70);
    check("t1_first_green_cycle", first_green, 4);
    check("t1_trace_len_ok", 32'(trace.size() >= 7), 1);
    for (int i = 0; i < 7 && i < trace.size(); i++) begin
      check($sformatf("t1_phase_%0d", i), trace[i].ph, exp_ph[i]);
      check($sformatf("t1_dwell_%0d", i), trace[i].dw, exp_dw[i]);
    end
    check("t1_back_to_ns_green", 32'(phase), 1);

    // 2. One-cycle request at cycle 10 cuts green at the cycle-12 tick.
    do_reset();
    run_to(9);
    ped_req = 1; step(); ped_req = 0;
    run_to(12); check("t2_cut_to_yellow", 32'(phase), 2);
    run_to(20); check("t2_allred", 32'(phase), 0);
    run_to(24); check("t2_walk_entry", 32'({phase, ped_ack}), {3'd5, 1'b1});
    step();     check("t2_ack_one_cycle", 32'(ped_ack), 0);
    run_to(36); check("t2_ew_green_after_walk", 32'(phase), 3);
    run_to(40);
    check("t2_walk_cycles", walk_cnt, 12);
    check("t2_ack_count", ack_cnt, 1);

    // 3. Request held through the walk: served once, then again next allred.
    enable = 1; ped_req = 1; reset = 1; step(); reset = 0;
    run_to(4);  check("t3_first_walk", 32'(phase), 5);
    run_to(17); check("t3_no_rewalk", 32'(phase), 1);
    run_to(24); check("t3_cut_again", 32'(phase), 2);
    run_to(36); check("t3_second_walk", 32'(phase), 5);
    run_to(40); check("t3_ack_count", ack_cnt, 2);
    ped_req = 0;

    // 4. Flash mode mid-green, requests during flash ignored.
    do_reset();
    run_to(10);
    enable = 0; step();
    check("t4_flash_entry", 32'({phase, light_ns, light_ew, walk}), {3'd6, 3'b001, 3'b001, 1'b0});
    run_to(15); check("t4_flash_off", 32'({light_ns, light_ew}), {3'b000, 3'b000});
    run_to(19); check("t4_flash_on", 32'({light_ns, light_ew}), {3'b001, 3'b001});
    run_to(20); ped_req = 1; run_to(23); ped_req = 0;
    run_to(30);
    enable = 1; step(); check("t4_reenable_allred", 32'(phase), 0);
    run_to(35); check("t4_ns_green", 32'(phase), 1);

    // 5. Reset in EW yellow discards a pending request.
    do_reset();
    run_to(57); check("t5_in_ew_yellow", 32'(phase), 4);
    ped_req = 1; step(); ped_req = 0;
    reset = 1; step(); reset = 0;
    check("t5_reset_state", 32'({phase, light_ns, light_ew, walk}), {3'd0, 3'b100, 3'b100, 1'b0});
    run_to(4); check("t5_pending_dropped", 32'(phase), 1);

    // 6. Request during allred after yellow goes straight to walk.
    do_reset();
    run_to(32); check("t6_allred", 32'(phase), 0);
    ped_req = 1; step(); ped_req = 0;
    run_to(36); check("t6_direct_walk", 32'(phase), 5);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ped_req = ($urandom_range(0, 15) == 0);
      if (low_left > 0) begin
        enable = 0; low_left--;
      end else begin
        enable = 1;
        if ($urandom_range(0, 299) == 0) low_left = $urandom_range(1, 15);
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
